// File: rtl/sram_mem_controller.sv
// MEM-stage data memory sequencer for an external 16-bit asynchronous SRAM.
// Each 32-bit load/store becomes two half-word accesses (low half first), then
// WAIT_CYCLES idle cycles, then a single-cycle DONE that releases the pipeline.
// The pipeline freezes on ~ready, so the request inputs normally stay stable.
// They are still latched in IDLE, so later changes cannot disturb a transaction.
module sram_mem_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  input  logic [15:0]            sram_dq_in,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic                   sram_ce_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n
);

  typedef enum logic [2:0] {
    StIdle,
    StAccLo,
    StAccHi,
    StWait,
    StDone
  } state_e;

  // Counter value on the last WAIT cycle; WAIT is never entered when WAIT_CYCLES is 0.
  localparam logic [3:0] WaitLast = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_wr_q, op_wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] offset;
  logic [31:0] word_idx;
  logic        hi_half;

  // State, counter, request latches and load data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic, request latching and half-word capture on reads.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (rd_en || wr_en) begin
          // A simultaneous read+write request is treated as a store.
          op_wr_d = wr_en;
          addr_d  = address;
          wdata_d = write_data;
          state_d = StAccLo;
        end
      end
      StAccLo: begin
        if (!op_wr_q) rdata_d[15:0] = sram_dq_in;
        state_d = StAccHi;
      end
      StAccHi: begin
        if (!op_wr_q) rdata_d[31:16] = sram_dq_in;
        cnt_d   = 4'd0;
        state_d = (WAIT_CYCLES == 0) ? StDone : StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WaitLast) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Half-word address of the latched request; out-of-range addresses wrap.
  assign offset    = addr_q - BASE_ADDR;
  assign word_idx  = offset >> 2;
  assign hi_half   = (state_q == StAccHi);
  assign sram_addr = SRAM_ADDR_W'({word_idx, hi_half});
  assign read_data = rdata_q;

  // Moore decode of the SRAM strobes and data bus, plus the ready handshake.
  always_comb begin
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_ce_n   = 1'b1;
    sram_ub_n   = 1'b1;
    sram_lb_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = 16'h0000;
    ready       = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = ~(rd_en | wr_en);
      end
      StAccLo, StAccHi: begin
        sram_ce_n = 1'b0;
        sram_ub_n = 1'b0;
        sram_lb_n = 1'b0;
        if (op_wr_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = hi_half ? wdata_q[31:16] : wdata_q[15:0];
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      StWait: begin
        ready = 1'b0;
      end
      StDone: begin
        ready = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Sequences the MEM-stage data memory on an external 16-bit asynchronous SRAM. It performs each 32-bit LDR/STR as two 16-bit half-word accesses plus a fixed wait period.
- Drives `ready`; the pipeline derives its freeze from `~ready`. While `ready` = 0, the IF/ID/EX/MEM and MEM/WB stage registers hold.
- Sits between the EX/MEM stage register and the MEM/WB stage register. `read_data` feeds the MEM/WB `mem_data` input.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM half-word 0.
- WAIT_CYCLES, 3: extra idle cycles after the second half-word access, before completion. Legal range 0..15.
- SRAM_ADDR_W, 18: width of the SRAM half-word address bus.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset.
- rd_en  in  1  load request (`mem_read` from EX/MEM).
- wr_en  in  1  store request (`mem_write` from EX/MEM).
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (Val_Rm).
- read_data  out  32  loaded word.
- ready  out  1  transaction complete / no transaction pending.
- sram_addr  out  SRAM_ADDR_W  half-word address.
- sram_dq_in  in  16  SRAM data bus, read direction.
- sram_dq_out  out  16  SRAM data bus, write direction.
- sram_dq_oe  out  1  1 = controller drives the data bus.
- sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM strobes.

Interface decision: one clock; reset is synchronous and active-high. The clock port is `clk` and the reset port is `rst`.

Behaviour:
- State register, one of: IDLE, ACC_LO, ACC_HI, WAIT, DONE. A 4-bit wait counter. Latched copies of op, address and write_data. All outputs other than `read_data` and `ready` are decoded from the state (Moore).
- Reset (synchronous, `rst` = 1 at a rising edge):
  - state <= IDLE, counter <= 0, read_data <= 0, all latches <= 0.
  - The bus is released immediately at the next edge, including when reset arrives mid-transaction. No partial write completes afterwards.
- IDLE:
  - `ready` = ~(rd_en | wr_en), combinational.
  - On a request, latch op, address and write_data, then go to ACC_LO.
  - If wr_en and rd_en are both 1, the transaction is a write; `read_data` is unchanged.
- Address mapping: `word_idx = (address - BASE_ADDR) >> 2`, computed modulo 2^32.
  - ACC_LO uses sram_addr = {word_idx, 1'b0}; ACC_HI uses sram_addr = {word_idx, 1'b1}. Both are truncated to SRAM_ADDR_W; out-of-range addresses wrap silently.
  - address[1:0] is ignored.
- ACC_LO / ACC_HI (one cycle each), shared settings:
  - sram_ce_n = 0, sram_ub_n = 0, sram_lb_n = 0.
- ACC_LO / ACC_HI, writes:
  - sram_we_n = 0, sram_oe_n = 1, sram_dq_oe = 1.
  - sram_dq_out = write_data[15:0] in ACC_LO, write_data[31:16] in ACC_HI.
- ACC_LO / ACC_HI, reads:
  - sram_we_n = 1, sram_oe_n = 0, sram_dq_oe = 0.
  - read_data[15:0] <= sram_dq_in at the edge leaving ACC_LO; read_data[31:16] <= sram_dq_in at the edge leaving ACC_HI.
- ACC_HI exit: go to WAIT with counter <= 0. If WAIT_CYCLES = 0, go directly to DONE.
- WAIT:
  - Counter increments each cycle. Go to DONE when counter = WAIT_CYCLES-1.
  - Strobes inactive (all _n = 1), sram_dq_oe = 0.
- DONE:
  - `ready` = 1 for exactly one cycle. The pipeline advances at this edge.
  - Next state is IDLE, unconditionally.
- In IDLE, WAIT and DONE: sram_we_n = 1, sram_oe_n = 1, sram_ce_n = 1, sram_dq_oe = 0, sram_dq_out = 0.
- Latency: a request first seen in IDLE at cycle 0 keeps `ready` = 0 for cycles 0..WAIT_CYCLES+2. `ready` = 1 in cycle WAIT_CYCLES+3 (cycle 6 at default).
- Back-to-back requests: a new request presented in the cycle after DONE restarts from IDLE with no bubble beyond the IDLE cycle.
- Inputs change mid-transaction: ignored; the latched copies are used.
- `read_data` holds its value until the next read's ACC_LO/ACC_HI captures.

Test Plan:
- Reset, then no requests: `ready` = 1, sram_ce_n = 1, sram_we_n = 1, sram_dq_oe = 0, read_data = 0 on every cycle.
- Write, address = 1024, write_data = 0xDEADBEEF, default params:
  - Half-word 0 receives 0xBEEF with sram_we_n = 0; half-word 1 receives 0xDEAD.
  - `ready` = 0 for 6 cycles, then 1 for one cycle.
- Read, address = 1024, with the behavioural SRAM model from the previous write: read_data = 0xDEADBEEF while `ready` = 1.
- Read, address = 1036, with the model holding 0x1234 at half-word 6 and 0xABCD at half-word 7: sram_addr = 6 then 7, read_data = 0xABCD1234.
- rd_en = 1 and wr_en = 1 together, address = 1028, data 0x00000055:
  - Write to half-words 2 and 3 occurs.
  - read_data is unchanged from its previous value.
- Boundary and disturbance cases:
  - Address 1020: wraps to half-words 0x3FFFE and 0x3FFFF.
  - WAIT_CYCLES = 0: `ready` = 1 in cycle 3.
  - `rst` in ACC_HI of a write: next cycle state IDLE, sram_we_n = 1, sram_dq_oe = 0, read_data = 0.
  - Changing `address` during WAIT does not alter sram_addr of the current transaction.
